// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: clears a 4-bit counter chain, prescales its count enable and counts chain wraps
module cnt_seq_ctrl #(
  parameter int PRE_W = 8,
  parameter int REP_W = 8
) (
  input  logic             CLK,
  input  logic             R_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic [PRE_W-1:0] PRESCALE,
  input  logic [REP_W-1:0] REPEAT,
  input  logic             CNT_CEO,
  output logic             CNT_R,
  output logic             CNT_CE,
  output logic             BUSY,
  output logic             DONE,
  output logic [REP_W-1:0] WRAP_CNT
);
  localparam logic [PRE_W-1:0] ONE_P = 1;
  localparam logic [REP_W-1:0] ONE_R = 1;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_e;
  state_e state_q;
  logic [PRE_W-1:0] pre_q, pre_d, ps_q;
  logic [REP_W-1:0] rep_q, wrap_q, wrap_d;
  logic mode_q, done_q, pre_end, wrap_ev, last_wrap;
  // Chain controls come only from registered state and prescaler so they cannot glitch
  always_comb begin
    pre_end   = pre_q == ps_q;
    pre_d     = pre_end ? '0 : pre_q + ONE_P;
    CNT_R     = state_q == CLEAR;
    CNT_CE    = state_q == RUN && pre_end;
    BUSY      = state_q != IDLE;
    wrap_ev   = CNT_CE && CNT_CEO;
    last_wrap = wrap_q + ONE_R == rep_q;
    wrap_d    = last_wrap ? '0 : wrap_q + ONE_R;
  end
  // Sequencer: latch config on start, one clear cycle, then prescaled run counting wraps
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      state_q <= IDLE;
      pre_q   <= '0;
      ps_q    <= '0;
      rep_q   <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (START && !STOP) begin
          mode_q  <= MODE;
          ps_q    <= PRESCALE;
          rep_q   <= REPEAT == '0 ? ONE_R : REPEAT;
          wrap_q  <= '0;
          state_q <= CLEAR;
        end
        CLEAR: begin
          pre_q   <= '0;
          wrap_q  <= '0;
          state_q <= STOP ? IDLE : RUN;
        end
        RUN: if (STOP) begin
          wrap_q  <= '0;
          state_q <= IDLE;
        end else begin
          pre_q <= pre_d;
          if (wrap_ev) begin
            wrap_q <= wrap_d;
            done_q <= last_wrap;
            if (last_wrap && !mode_q) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign DONE     = done_q;
  assign WRAP_CNT = wrap_q;
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: scoreboard bench; a timing model predicts every cycle's outputs from the start edge
module tb_cnt_seq_ctrl;
  logic clk = 1'b0, r_n = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [7:0] prescale = '0, rep_i = '0, wrap_cnt;
  logic cnt_ceo, cnt_r, cnt_ce, busy, done;
  logic [3:0] cnt = '0;
  typedef struct packed {logic r; logic ce; logic busy; logic done; logic [7:0] wc;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0;
  bit m_act = 0, m_md = 0;
  int m_s = 0, m_p = 0, m_r = 1;

  always #5 clk = ~clk;

  // One 4-bit chain stage: sync reset, enable, terminal count
  always_ff @(posedge clk) cnt <= cnt_r ? 4'h0 : cnt_ce ? cnt + 4'h1 : cnt;
  assign cnt_ceo = cnt == 4'hf && cnt_ce;

  cnt_seq_ctrl #(.PRE_W(8), .REP_W(8)) dut (
    .CLK(clk), .R_N(r_n), .START(start), .STOP(stop), .MODE(mode),
    .PRESCALE(prescale), .REPEAT(rep_i), .CNT_CEO(cnt_ceo),
    .CNT_R(cnt_r), .CNT_CE(cnt_ce), .BUSY(busy), .DONE(done), .WRAP_CNT(wrap_cnt)
  );

  function automatic void chk(string n, logic [7:0] got, logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", n, cyc, got, want);
    end
  endfunction

  // Outputs in cycle c of a run accepted at edge m_s: clear in m_s+1, then CE every
  // (p+1) cycles, one wrap per 16 CEs, DONE the cycle after every r-th wrap
  function automatic exp_t predict(int c);
    exp_t x;
    int j, q, m, w;
    x = '0;
    if (!m_act) return x;
    if (c == m_s + 1) begin
      x.r = 1'b1;
      x.busy = 1'b1;
      return x;
    end
    j = c - m_s - 2;
    q = m_p + 1;
    m = j / q;
    w = m / 16;
    x.done = j >= 1 && j % q == 0 && m % 16 == 0 && w % m_r == 0;
    if (!m_md && w >= m_r) begin
      m_act = 0;
      return x;
    end
    x.ce = (j + 1) % q == 0;
    x.busy = 1'b1;
    x.wc = 8'(w % m_r);
    return x;
  endfunction

  // Drive one cycle's inputs, let the edge happen, then queue the model's prediction
  task automatic step(bit rn, bit st, bit sp, bit md, int ps, int rp);
    #1;
    if (!rn && r_n) begin
      m_act = 0;
      if (sb.size() > 0) sb[sb.size()-1] = '0;
    end
    r_n = rn; start = st; stop = sp; mode = md;
    prescale = 8'(ps); rep_i = 8'(rp);
    @(posedge clk);
    cyc++;
    if (!r_n) m_act = 0;
    else if (!m_act) begin
      if (start && !stop) begin
        m_act = 1; m_s = cyc; m_md = mode; m_p = prescale;
        m_r = rep_i == 8'd0 ? 1 : int'(rep_i);
      end
    end else if (stop) m_act = 0;
    sb.push_back(predict(cyc + 1));
  endtask

  task automatic tick(bit rn, bit st, bit sp);
    step(rn, st, sp, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0);
  endtask

  task automatic go(bit md, int ps, int rp);
    step(1, 1, 0, md, ps, rp);
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the queued prediction
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("cnt_r", {7'd0, cnt_r}, {7'd0, x.r});
        chk("cnt_ce", {7'd0, cnt_ce}, {7'd0, x.ce});
        chk("busy", {7'd0, busy}, {7'd0, x.busy});
        chk("done", {7'd0, done}, {7'd0, x.done});
        chk("wrap_cnt", wrap_cnt, x.wc);
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized runs with stray start/stop/reset
  initial begin
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    idle(2);
    go(0, 0, 1); idle(20);
    chk("chain_zero", {4'd0, cnt}, 8'd0);
    go(0, 2, 1); idle(55);
    go(1, 0, 2); idle(100); tick(1, 0, 1); idle(3);
    go(0, 0, 1); idle(9); tick(1, 0, 1); idle(5);
    go(0, 0, 1); idle(20);
    tick(1, 1, 1); idle(3);
    go(0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255));
    idle(30);
    go(1, 0, 1); idle(8);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    idle(2);
    go(0, 0, 0); idle(20);
    for (int n = 0; n < 30; n++) begin
      int ps, rp, len;
      ps = $urandom_range(0, 3);
      rp = $urandom_range(0, 3);
      idle($urandom_range(0, 3));
      go(1'($urandom_range(0, 1)), ps, rp);
      len = 32 * (ps + 1) * (rp == 0 ? 1 : rp) + 5;
      len = $urandom_range(len / 4, len);
      for (int i = 0; i < len; i++) begin
        int k;
        k = $urandom_range(0, 199);
        if (k < 2) tick(1, 0, 1);
        else if (k < 3) tick(0, 0, 0);
        else tick(1, k < 10, 0);
      end
      tick(1, 0, 1);
    end
    idle(4);
    @(negedge clk);
    #1;
    chk("sb_drain", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
